// File: rtl/binarize_pkg.sv
// Shared constants for the YCbCr binariser: config register map, CTRL bits, threshold defaults.
// No logic; latency and backpressure do not apply.
package binarize_pkg;

  localparam logic [2:0] CFG_ADDR_TA   = 3'd0;
  localparam logic [2:0] CFG_ADDR_TB   = 3'd1;
  localparam logic [2:0] CFG_ADDR_TC   = 3'd2;
  localparam logic [2:0] CFG_ADDR_TD   = 3'd3;
  localparam logic [2:0] CFG_ADDR_CTRL = 3'd4;

  localparam int CTRL_INVERT_BIT = 0;
  localparam int CTRL_BYPASS_BIT = 1;

  localparam int DEF_TA = 72;
  localparam int DEF_TB = 130;
  localparam int DEF_TC = 140;
  localparam int DEF_TD = 210;

endpackage

// File: rtl/range_check.sv
// Registered strict window compare: in_range = lo < x < hi, unsigned.
// Latency 1 cycle; no backpressure.
module range_check #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  output logic              in_range
);

  always_ff @(posedge clk) begin
    if (rst) begin
      in_range <= 1'b0;
    end else begin
      in_range <= (x > lo) && (x < hi);
    end
  end

endmodule

// File: rtl/binarize_stream.sv
// Streaming YCbCr window binariser with frame-shadowed thresholds and per-frame foreground count.
// Latency 2 cycles on pixel and syncs; no backpressure (free-running video stream).
module binarize_stream
  import binarize_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TA_DEF = DEF_TA,
  parameter int TB_DEF = DEF_TB,
  parameter int TC_DEF = DEF_TC,
  parameter int TD_DEF = DEF_TD,
  parameter int CNT_W  = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                de_in,
  input  logic                h_sync_in,
  input  logic                v_sync_in,
  input  logic [3*DATA_W-1:0] pixel_in,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [DATA_W-1:0]   cfg_data,
  output logic                de_out,
  output logic                h_sync_out,
  output logic                v_sync_out,
  output logic [3*DATA_W-1:0] pixel_out,
  output logic                mask_out,
  output logic [CNT_W-1:0]    fg_count,
  output logic                fg_count_valid
);

  localparam logic [DATA_W-1:0] TA_RST  = DATA_W'(TA_DEF);
  localparam logic [DATA_W-1:0] TB_RST  = DATA_W'(TB_DEF);
  localparam logic [DATA_W-1:0] TC_RST  = DATA_W'(TC_DEF);
  localparam logic [DATA_W-1:0] TD_RST  = DATA_W'(TD_DEF);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [DATA_W-1:0]   r_pend_ta, r_pend_tb, r_pend_tc, r_pend_td;
  logic [DATA_W-1:0]   r_act_ta, r_act_tb, r_act_tc, r_act_td;
  logic [1:0]          r_pend_ctrl, r_act_ctrl;
  logic                r_vin_prev;
  logic                w_vin_rise;

  logic                r_de1, r_hs1, r_vs1;
  logic [3*DATA_W-1:0] r_pix1;
  logic [1:0]          r_ctrl1;
  logic                w_cb_ok, w_cr_ok;
  logic                w_hit, w_mask;
  logic [3*DATA_W-1:0] w_pix;

  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                r_vout_prev;
  logic                w_vout_rise;

  assign w_vin_rise = v_sync_in & ~r_vin_prev;

  // Writes land in the pending set; the active set only swaps at a frame boundary,
  // so a write coinciding with the boundary waits for the following one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_ta   <= TA_RST;
      r_pend_tb   <= TB_RST;
      r_pend_tc   <= TC_RST;
      r_pend_td   <= TD_RST;
      r_pend_ctrl <= 2'b00;
      r_act_ta    <= TA_RST;
      r_act_tb    <= TB_RST;
      r_act_tc    <= TC_RST;
      r_act_td    <= TD_RST;
      r_act_ctrl  <= 2'b00;
      r_vin_prev  <= 1'b1;
    end else begin
      r_vin_prev <= v_sync_in;
      if (w_vin_rise) begin
        r_act_ta   <= r_pend_ta;
        r_act_tb   <= r_pend_tb;
        r_act_tc   <= r_pend_tc;
        r_act_td   <= r_pend_td;
        r_act_ctrl <= r_pend_ctrl;
      end
      if (cfg_we) begin
        case (cfg_addr)
          CFG_ADDR_TA:   r_pend_ta   <= cfg_data;
          CFG_ADDR_TB:   r_pend_tb   <= cfg_data;
          CFG_ADDR_TC:   r_pend_tc   <= cfg_data;
          CFG_ADDR_TD:   r_pend_td   <= cfg_data;
          CFG_ADDR_CTRL: r_pend_ctrl <= cfg_data[CTRL_BYPASS_BIT:CTRL_INVERT_BIT];
          default:       ;
        endcase
      end
    end
  end

  range_check #(.DATA_W(DATA_W)) u_cb_check (
    .clk      (clk),
    .rst      (rst),
    .x        (pixel_in[2*DATA_W-1:DATA_W]),
    .lo       (r_act_ta),
    .hi       (r_act_tb),
    .in_range (w_cb_ok)
  );

  range_check #(.DATA_W(DATA_W)) u_cr_check (
    .clk      (clk),
    .rst      (rst),
    .x        (pixel_in[DATA_W-1:0]),
    .lo       (r_act_tc),
    .hi       (r_act_td),
    .in_range (w_cr_ok)
  );

  // CTRL travels with the pixel so a frame-boundary swap cannot split a pixel's settings.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_de1   <= 1'b0;
      r_hs1   <= 1'b0;
      r_vs1   <= 1'b0;
      r_pix1  <= '0;
      r_ctrl1 <= 2'b00;
    end else begin
      r_de1   <= de_in;
      r_hs1   <= h_sync_in;
      r_vs1   <= v_sync_in;
      r_pix1  <= pixel_in;
      r_ctrl1 <= r_act_ctrl;
    end
  end

  always_comb begin
    w_hit  = (w_cb_ok & w_cr_ok) ^ r_ctrl1[CTRL_INVERT_BIT];
    w_mask = w_hit & r_de1;
    w_pix  = '0;
    if (r_de1) begin
      w_pix = r_ctrl1[CTRL_BYPASS_BIT] ? r_pix1 : {(3*DATA_W){w_mask}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_out     <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
      pixel_out  <= '0;
      mask_out   <= 1'b0;
    end else begin
      de_out     <= r_de1;
      h_sync_out <= r_hs1;
      v_sync_out <= r_vs1;
      pixel_out  <= w_pix;
      mask_out   <= w_mask;
    end
  end

  assign w_cnt_inc   = (mask_out && (r_cnt != CNT_MAX)) ? r_cnt + 1'b1 : r_cnt;
  assign w_vout_rise = v_sync_out & ~r_vout_prev;

  // The snapshot includes the boundary cycle's own hit, then counting restarts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      fg_count       <= '0;
      fg_count_valid <= 1'b0;
      r_vout_prev    <= 1'b1;
    end else begin
      r_vout_prev    <= v_sync_out;
      fg_count_valid <= w_vout_rise;
      if (w_vout_rise) begin
        fg_count <= w_cnt_inc;
        r_cnt    <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

endmodule
